// File: rtl/qspi_resp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | qspi_resp_pkg: opcodes, FSM encoding and dummy-cycle count for         |
// | qspi_flash_responder.                                                  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package qspi_resp_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam int DUMMY_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_ID     = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/qspi_flash_responder_pin_sync.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spi_pin_sync: SYNC_STAGES-deep synchronizers for sck/cs_n/mosi with    |
// | sck and cs_n edge events taken from the two oldest stages.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  localparam int L = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] mosi_q;

  // cs_n chain resets to the deselected level so reset release is not a falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q  <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sck_q[0]  <= sck;
      cs_q[0]   <= cs_n;
      mosi_q[0] <= mosi;
      for (int i = L; i > 0; i--) begin
        sck_q[i]  <= sck_q[i-1];
        cs_q[i]   <= cs_q[i-1];
        mosi_q[i] <= mosi_q[i-1];
      end
    end
  end

  assign sck_rise = sck_q[L-1] & ~sck_q[L];
  assign sck_fall = ~sck_q[L-1] & sck_q[L];
  assign cs_fall  = ~cs_q[L-1] & cs_q[L];
  assign cs_rise  = cs_q[L-1] & ~cs_q[L];
  assign mosi_s   = mosi_q[L];

endmodule
`default_nettype wire

// File: rtl/qspi_flash_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | qspi_flash_responder: SPI mode-0 flash responder (READ 0x03, RDID 0x9F)|
// | serving bytes from a synchronous ROM port. Define                      |
// | QSPI_RESP_FAST_READ_EN to also accept FAST READ 0x0B.                   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module qspi_flash_responder
  import qspi_resp_pkg::*;
#(
  parameter int          ADDR_W      = 24,
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  state_t      state, state_nx;
  logic        sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;
  logic [4:0]  bit_cnt;
  logic [22:0] rx_sr;
  logic [23:0] rx_word;
  logic [23:0] tx_sr;
  logic        rd_pend;
  logic        fast;
  logic        op_err;
  logic        rd_launch;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .sck      (spi_sck),
    .cs_n     (spi_cs_n),
    .mosi     (spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .mosi_s   (mosi_s)
  );

  assign rx_word = {rx_sr, mosi_s};

`ifdef QSPI_RESP_FAST_READ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            fast <= 1'b0;
    else if (state == ST_CMD && sck_rise) fast <= (rx_word[7:0] == OP_FAST_READ);
  end
`else
  assign fast = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // cs_n deassertion overrides any sck event seen in the same cycle
  always_comb begin
    state_nx  = state;
    op_err    = 1'b0;
    rd_launch = 1'b0;
    if (cs_rise) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_nx = ST_CMD;
        ST_CMD: if (sck_rise && bit_cnt == 5'd7) begin
          case (rx_word[7:0])
            OP_READ:      state_nx = ST_ADDR;
            OP_RDID:      state_nx = ST_ID;
`ifdef QSPI_RESP_FAST_READ_EN
            OP_FAST_READ: state_nx = ST_ADDR;
`endif
            default: begin
              state_nx = ST_IGNORE;
              op_err   = 1'b1;
            end
          endcase
        end
        ST_ADDR: if (sck_rise && bit_cnt == 5'd23) begin
          state_nx  = fast ? ST_DUMMY : ST_DATA;
          rd_launch = ~fast;
        end
        ST_DUMMY: if (sck_rise && bit_cnt == 5'(DUMMY_CYCLES - 1)) begin
          state_nx  = ST_DATA;
          rd_launch = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      rd_pend     <= 1'b0;
    end else begin
      mem_rd  <= rd_launch;
      cmd_err <= op_err;
      rd_pend <= mem_rd;
      if (cs_rise) begin
        busy        <= 1'b0;
        spi_miso_oe <= 1'b0;
        spi_miso    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (cs_fall) begin
            busy    <= 1'b1;
            bit_cnt <= '0;
            rx_sr   <= '0;
          end
          ST_CMD: if (sck_rise) begin
            rx_sr   <= rx_word[22:0];
            bit_cnt <= (state_nx != state) ? 5'd0 : bit_cnt + 5'd1;
            if (state_nx == ST_ID) tx_sr <= JEDEC_ID;
          end
          ST_ADDR: if (sck_rise) begin
            rx_sr   <= rx_word[22:0];
            bit_cnt <= (state_nx != state) ? 5'd0 : bit_cnt + 5'd1;
            if (state_nx != state) mem_addr <= rx_word[ADDR_W-1:0];
          end
          ST_DUMMY: if (sck_rise) begin
            bit_cnt <= (state_nx != state) ? 5'd0 : bit_cnt + 5'd1;
          end
          ST_DATA: begin
            // a fetched byte lands in the top of the shifter well before the next fall
            if (rd_pend) begin
              tx_sr[23:16] <= mem_rdata;
            end else if (sck_fall) begin
              spi_miso    <= tx_sr[23];
              tx_sr       <= {tx_sr[22:0], 1'b0};
              spi_miso_oe <= 1'b1;
            end
            if (sck_rise) begin
              bit_cnt <= {2'b00, bit_cnt[2:0] + 3'd1};
              if (bit_cnt[2:0] == 3'd7) begin
                mem_addr <= mem_addr + 1'b1;
                mem_rd   <= 1'b1;
              end
            end
          end
          ST_ID: if (sck_fall) begin
            spi_miso    <= tx_sr[23];
            tx_sr       <= {tx_sr[22:0], 1'b0};
            spi_miso_oe <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
- Synthesizable SPI-flash responder (slave): the other end of the SoC's QSPI0 boot/XiP initiator.
- Lets the E203 QSPI master boot from FPGA block RAM instead of the board flash during bring-up and simulation.
- Sits between the qspi0 pads (sck, cs, dq0 in, dq1 out) and a synchronous read-only memory port.
- Single-bit SPI mode 0; supports READ (0x03) and JEDEC ID (0x9F).

Parameters:
- ADDR_W, 24, flash byte-address width; address wraps at 2^ADDR_W.
- SYNC_STAGES, 2, synchronizer depth for sck/cs_n/mosi (min 2).
- JEDEC_ID, 24'hEF4018, three ID bytes returned MSB-first for 0x9F.

Ports:
- clk  in  1  system clock, must be >= 8x sck frequency.
- reset  in  1  asynchronous, active-high reset.
- spi_sck  in  1  SPI clock from master (asynchronous to clk).
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  dq0 from master.
- spi_miso  out  1  dq1 to master.
- spi_miso_oe  out  1  output enable for the dq1 IOBUF.
- mem_rd  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  byte read address.
- mem_rdata  in  8  read data, valid exactly 1 clk after mem_rd.
- busy  out  1  high while a transaction is in progress (cs_n low).
- cmd_err  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, mem_rd=0, mem_addr=0, busy=0, cmd_err=0; FSM in IDLE.
- Input synchronization: sck, cs_n and mosi each pass through SYNC_STAGES flops. Rising and falling sck events come from the last two sync stages.
- mosi is sampled on the sck rise event; miso updates on the sck fall event. Input-to-event latency is SYNC_STAGES+1 clk.
- FSM states: IDLE -> CMD -> {ADDR, ID, IGNORE} -> DATA.
  - IDLE: on sync cs_n falling go to CMD, clear the bit counter, busy=1.
  - CMD: shift 8 bits in MSB-first.
    - After the 8th rise: 0x03 -> ADDR, 0x9F -> ID, any other opcode -> IGNORE with cmd_err pulsed 1 clk.
  - ADDR: shift in 24 bits MSB-first and keep the low ADDR_W bits.
    - On the 24th rise, mem_rd=1 with mem_addr=that address.
    - Next clk: load the shift register from mem_rdata and go to DATA.
  - DATA: each fall shifts out the next bit MSB-first. spi_miso_oe=1 from the first fall in DATA.
    - On the rise that samples bit 0 of the current byte: increment mem_addr (wrapping 2^ADDR_W-1 -> 0) and pulse mem_rd.
    - The fetched byte loads before the next fall. Reads are unbounded.
  - ID: shift JEDEC_ID out MSB-first for 24 bits, then drive 0 with oe=1 until cs_n rises.
  - IGNORE: miso_oe=0, ignore sck until cs_n rises.
- cs_n rise, in any state: within 1 clk after sync go to IDLE, miso_oe=0, busy=0.
  - Partial bytes or addresses are discarded.
  - An mem_rd already in flight completes, but its data is dropped.
- sck activity while cs_n is high is ignored.
- Simultaneous cs_n rise and sck edge in the same clk: cs_n wins.
- Asynchronous reset mid-transaction: immediately IDLE with all outputs at reset values. The master must re-assert cs_n to restart.
- Minimum sck half-period is 4 clk. Faster sck is out of spec; behaviour is undefined and no assertion is required.

Optional Feature:
- Macro QSPI_RESP_FAST_READ_EN.
- Defined: opcode 0x0B is accepted. The FSM goes ADDR -> DUMMY (8 sck rises, mosi ignored, oe=0) -> DATA. mem_rd is issued on the 8th dummy rise.
- Undefined: 0x0B is treated as unsupported (IGNORE + cmd_err).

Decomposition:
- Package qspi_resp_pkg:
  - opcode constants OP_READ=8'h03, OP_RDID=8'h9F, OP_FAST_READ=8'h0B;
  - state enum encoding;
  - DUMMY_CYCLES=8.
- One sub-module, spi_pin_sync: SYNC_STAGES synchronizer plus edge detect for sck and cs_n.

Test Plan:
- Memory model returns addr[7:0]^8'hA5. Command 0x03 with address 0x000010, then 4 bytes -> miso bytes B5,B4,B7,B6 and mem_addr 0x10..0x13.
- Command 0x9F, then 4 bytes -> EF,40,18,00; mem_rd never asserted.
- Command 0x03 at 0xFFFFFF, then 2 bytes -> 5A then A5; mem_addr wraps to 0x000000.
- Opcode 0x55 -> cmd_err single pulse, miso_oe stays 0, busy stays high until cs_n rises.
- cs_n deasserted after 12 address bits, then a new 0x03 at 0x000001 -> first byte A4 with no residue from the aborted transaction. Also: reset asserted mid-DATA -> all outputs 0 within 0 clk.
- With QSPI_RESP_FAST_READ_EN: 0x0B at 0x000002 plus 8 dummy clocks -> first byte A7, oe low during dummy. Without the macro: cmd_err pulse.
